// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   - default sizing for the core array and the data memory
//   - FSM state encoding (2 bits, legacy-compatible localparams)
//   - grant_width(): width of a core index, never narrower than 1 bit
package data_mem_arbiter_pkg;

    localparam int CORE_COUNT_DEF = 4;
    localparam int DATA_WIDTH_DEF = 12;
    localparam int DEPTH_DEF      = 4096;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GRANT_W = grant_width(CORE_COUNT_DEF);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle between the core array, the arbiter and the single-port data memory.
//   Core side : req, reqWrEn, reqAddr, reqData (in to arbiter), ack, rdData (out)
//   Memory side: memWrEn, memAddress, memDataIn (out of arbiter), memDataOut (in)
// Handshake: core i raises req[i] with reqWrEn/reqAddr/reqData stable and keeps
// it high until it sees ack[i]; ack[i] is a single-cycle pulse and completes the
// access (rdData is valid in that cycle for a read). The core drops req on the
// edge that samples ack; the arbiter does not look at req again before then.
// modport master: the arbiter's view. modport slave: cores + memory view.
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int CORE_COUNT = CORE_COUNT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic [CORE_COUNT-1:0]            req;
    logic [CORE_COUNT-1:0]            reqWrEn;
    logic [CORE_COUNT*ADDR_WIDTH-1:0] reqAddr;
    logic [CORE_COUNT*DATA_WIDTH-1:0] reqData;
    logic [CORE_COUNT-1:0]            ack;
    logic [DATA_WIDTH-1:0]            rdData;
    logic                             memWrEn;
    logic [ADDR_WIDTH-1:0]            memAddress;
    logic [DATA_WIDTH-1:0]            memDataIn;
    logic [DATA_WIDTH-1:0]            memDataOut;

    modport master (
        input  req, reqWrEn, reqAddr, reqData, memDataOut,
        output ack, rdData, memWrEn, memAddress, memDataIn
    );

    modport slave (
        output req, reqWrEn, reqAddr, reqData, memDataOut,
        input  ack, rdData, memWrEn, memAddress, memDataIn
    );
endinterface

// File: rtl/data_mem_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i        : request vector, one bit per core
//   last_grant_i : index of the most recently granted core
//   valid_o      : at least one request present
//   winner_o     : first requesting core scanning last+1, last+2, ... (wrapping)
// The wrap is an explicit compare so CORE_COUNT need not be a power of two.
module rr_priority_picker #(
    parameter int CORE_COUNT = 4,
    parameter int GW         = 2
) (
    input  logic [CORE_COUNT-1:0] req_i,
    input  logic [GW-1:0]         last_grant_i,
    output logic                  valid_o,
    output logic [GW-1:0]         winner_o
);
    logic [GW-1:0] scan_idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        scan_idx = last_grant_i;
        for (int k = 0; k < CORE_COUNT; k++) begin
            scan_idx = (scan_idx == GW'(CORE_COUNT - 1)) ? '0 : scan_idx + GW'(1);
            if (!valid_o && req_i[scan_idx]) begin
                valid_o  = 1'b1;
                winner_o = scan_idx;
            end
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin initiator for the shared single-port data memory.
//   clk, rstN   : single clock, asynchronous active-low reset
//   bus         : core request/ack side and memory port (master modport)
//   dbg_state_o : current FSM state for observation
// One access takes IDLE -> ISSUE -> CAPTURE -> DONE; every output is registered.
// memWrEn is high only in the ISSUE cycle, so each write strobes exactly once.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int CORE_COUNT = CORE_COUNT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstN,
    data_mem_arbiter_if.master  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int GW = grant_width(CORE_COUNT);

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q, last_d;
    logic                  op_wr_q, op_wr_d;
    logic [CORE_COUNT-1:0] ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;

    rr_priority_picker #(
        .CORE_COUNT (CORE_COUNT),
        .GW         (GW)
    ) u_picker (
        .req_i        (bus.req),
        .last_grant_i (last_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        op_wr_d = op_wr_q;
        ack_d   = ack_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                wr_d = 1'b0;
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = bus.reqAddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d   = bus.reqData[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wr_d    = bus.reqWrEn[pick_idx];
                    op_wr_d = bus.reqWrEn[pick_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Memory acts on this edge; the strobe must not last longer.
                wr_d    = 1'b0;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Registered read data is on memDataOut now; writes keep old rdData.
                if (!op_wr_q) rd_d = bus.memDataOut;
                ack_d          = '0;
                ack_d[grant_q] = 1'b1;
                state_d        = ST_DONE;
            end
            default: begin
                // DONE: the core drops req on this edge, so req is ignored here.
                ack_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(CORE_COUNT - 1);
            op_wr_q <= 1'b0;
            ack_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            op_wr_q <= op_wr_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rdData     = rd_q;
    assign bus.memWrEn    = wr_q;
    assign bus.memAddress = addr_q;
    assign bus.memDataIn  = din_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: data memory responder, core drivers, a
// transaction-level reference (round-robin by modular arithmetic over the
// request set seen at the arbitration edge, memory as a plain array).
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int NC    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int STARVE_BOUND = 4*NC + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.CORE_COUNT(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    logic [1:0] dbg_state;

    data_mem_arbiter #(
        .CORE_COUNT (NC),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- data memory: write-first, 1-cycle registered read ----------------
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (bus.memWrEn) begin
            mem[bus.memAddress] <= bus.memDataIn;
            bus.memDataOut      <= bus.memDataIn;
        end else begin
            bus.memDataOut      <= mem[bus.memAddress];
        end
    end

    // ---------------- core drive ----------------
    logic [NC-1:0]    req_v = '0;
    logic [NC-1:0]    wr_v  = '0;
    logic [AW-1:0]    addr_a [NC] = '{default: '0};
    logic [DW-1:0]    data_a [NC] = '{default: '0};
    logic [NC*AW-1:0] addr_flat;
    logic [NC*DW-1:0] data_flat;

    always_comb begin
        addr_flat = '0;
        data_flat = '0;
        for (int c = 0; c < NC; c++) begin
            addr_flat[c*AW +: AW] = addr_a[c];
            data_flat[c*DW +: DW] = data_a[c];
        end
    end
    assign bus.req     = req_v;
    assign bus.reqWrEn = wr_v;
    assign bus.reqAddr = addr_flat;
    assign bus.reqData = data_flat;

    // ---------------- scoreboard / reference ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [GRANT_W-1:0] exp_q[$];
    logic [NC-1:0]      hist_q[$];
    logic [DW-1:0]      ref_mem [DEPTH] = '{default: '0};
    int                 ref_last = NC - 1;
    logic [DW-1:0]      ref_rd = '0;
    int                 cyc = 0;
    int                 raise_cyc [NC] = '{default: 0};
    int                 again [NC] = '{default: 0};
    logic [NC-1:0]      drop_pend = '0;
    int                 wr_pulses = 0;
    int                 write_acks = 0;
    bit                 got_ack = 1'b0;
    int                 got_core = 0;

    typedef struct {
        int core;
        bit wr;
        int addr;
        int data;
        int exp_rd;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic raise(input int c, input bit wr, input int addr, input int data);
        wr_v[c]      = wr;
        addr_a[c]    = AW'(addr);
        data_a[c]    = DW'(data);
        req_v[c]     = 1'b1;
        raise_cyc[c] = cyc;
    endtask

    task automatic rand_op(input int c);
        int a;
        a = $urandom_range(0, 15);
        if (a >= 8) a = 'hFF0 + a;
        raise(c, 1'($urandom_range(0, 1)), a, $urandom_range(0, 4095));
    endtask

    task automatic clear_model();
        req_v     = '0;
        drop_pend = '0;
        for (int i = 0; i < NC; i++) again[i] = 0;
        hist_q.delete();
        ref_last  = NC - 1;
        ref_rd    = '0;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        clear_model();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // One cycle: record the request set the next edge samples, then at the
    // following negedge score any ack against the reference.
    task automatic step();
        logic [NC-1:0] seen;
        logic [NC-1:0] snap;
        int c;
        int exp_w;
        hist_q.push_back(req_v);
        if (hist_q.size() > 4) void'(hist_q.pop_front());
        @(negedge clk);
        cyc++;
        if (bus.memWrEn) wr_pulses++;
        got_ack = 1'b0;
        seen = bus.ack;
        if (seen != '0) begin
            got_ack = 1'b1;
            check("ack_onehot", $countones(seen), 1);
            c = 0;
            for (int i = NC - 1; i >= 0; i--) if (seen[i]) c = i;
            got_core = c;
            // Arbitration edge was 3 cycles before the ack is seen.
            snap = (hist_q.size() >= 3) ? hist_q[hist_q.size() - 3] : '0;
            exp_w = -1;
            for (int d = 1; d <= NC; d++)
                if (exp_w < 0 && snap[(ref_last + d) % NC]) exp_w = (ref_last + d) % NC;
            check("rr_winner", c, exp_w);
            ref_last = c;
            check("starve_bound", 32'(cyc - raise_cyc[c] <= STARVE_BOUND), 1);
            if (wr_v[c]) begin
                ref_mem[addr_a[c]] = data_a[c];
                write_acks++;
                check("rd_hold_on_write", bus.rdData, ref_rd);
            end else begin
                ref_rd = ref_mem[addr_a[c]];
                check("rd_data", bus.rdData, ref_rd);
            end
            if (exp_q.size() > 0) check("grant_order", c, exp_q.pop_front());
        end
        for (int i = 0; i < NC; i++) begin
            if (drop_pend[i]) begin
                if (again[i] > 0) begin
                    again[i]--;
                    raise_cyc[i] = cyc;
                end else begin
                    req_v[i] = 1'b0;
                end
            end
        end
        drop_pend = seen;
    endtask

    task automatic access(input string name, input int c, input bit wr,
                          input int addr, input int data, input int exp_rd);
        int w0;
        int lat;
        bit got;
        logic [DW-1:0] rd;
        w0 = wr_pulses;
        got = 1'b0;
        lat = 0;
        rd = '0;
        raise(c, wr, addr, data);
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (got_ack && got_core == c) begin
                got = 1'b1;
                lat = cyc - raise_cyc[c];
                rd  = bus.rdData;
            end
        end
        check({name, "_acked"}, 32'(got), 1);
        if (got) begin
            check({name, "_latency"}, lat, 3);
            check({name, "_rdData"}, rd, exp_rd);
        end
        step();
        step();
        check({name, "_wr_pulses"}, wr_pulses - w0, 32'(wr));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int t0;
        int w0;
        int wa0;
        bit r0;
        int acyc[$];

        vecs[0] = '{1, 1'b1, 'h010, 'hABC, 'h000};
        vecs[1] = '{1, 1'b0, 'h010, 'h000, 'hABC};
        vecs[2] = '{2, 1'b1, 'hFFF, 'h123, 'hABC};
        vecs[3] = '{0, 1'b0, 'hFFF, 'h000, 'h123};
        vecs[4] = '{3, 1'b0, 'h000, 'h000, 'h000};
        vecs[5] = '{0, 1'b1, 'h800, 'h5A5, 'h000};
        vecs[6] = '{2, 1'b0, 'h800, 'h000, 'h5A5};

        // Reset values while held in reset.
        rstN = 1'b1;
        #1 rstN = 1'b0;
        @(negedge clk);
        check("rst_ack",     bus.ack, 0);
        check("rst_rdData",  bus.rdData, 0);
        check("rst_memWrEn", bus.memWrEn, 0);
        check("rst_memAddr", bus.memAddress, 0);
        check("rst_memDin",  bus.memDataIn, 0);
        check("rst_state",   dbg_state, ST_IDLE);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_memWrEn", bus.memWrEn, 0);
            check("idle_state",   dbg_state, ST_IDLE);
            check("idle_ack",     bus.ack, 0);
        end

        // Table-driven single accesses, including 0xFFF / 0x000 boundaries.
        for (int i = 0; i < 7; i++)
            access($sformatf("vec%0d", i), vecs[i].core, vecs[i].wr,
                   vecs[i].addr, vecs[i].data, vecs[i].exp_rd);

        // Contention: all four read from reset, core0 asks twice.
        do_reset();
        for (int g = 0; g < 4; g++) exp_q.push_back(GRANT_W'(g));
        exp_q.push_back(GRANT_W'(0));
        again[0] = 1;
        t0 = cyc;
        raise(0, 1'b0, 'h010, 0);
        raise(1, 1'b0, 'hFFF, 0);
        raise(2, 1'b0, 'h800, 0);
        raise(3, 1'b0, 'h000, 0);
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            step();
            if (got_ack) begin
                acyc.push_back(cyc);
                n++;
            end
        end
        step();
        step();
        check("cont_count", n, 5);
        if (acyc.size() > 0) check("cont_first_lat", acyc[0] - t0, 3);
        for (int i = 1; i < acyc.size(); i++) check("cont_spacing", acyc[i] - acyc[i-1], 4);
        check("cont_exp_left", exp_q.size(), 0);

        // Fairness: core3 keeps asking, core0 joins after core3's first grant.
        do_reset();
        exp_q.push_back(GRANT_W'(3));
        exp_q.push_back(GRANT_W'(0));
        for (int g = 0; g < 3; g++) exp_q.push_back(GRANT_W'(3));
        again[3] = 3;
        raise(3, 1'b0, 'h010, 0);
        r0 = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            step();
            if (got_ack) n++;
            if (got_ack && got_core == 3 && !r0) begin
                raise(0, 1'b0, 'hFFF, 0);
                r0 = 1'b1;
            end
        end
        step();
        step();
        check("fair_count", n, 5);
        check("fair_exp_left", exp_q.size(), 0);

        // Randomised traffic against the reference.
        w0  = wr_pulses;
        wa0 = write_acks;
        for (int i = 0; i < 400; i++) begin
            step();
            for (int c = 0; c < NC; c++)
                if (!req_v[c] && $urandom_range(0, 3) == 0) rand_op(c);
        end
        for (int i = 0; i < 100 && req_v != '0; i++) step();
        step();
        step();
        check("rand_drained", req_v, 0);
        check("rand_wr_pulses", wr_pulses - w0, write_acks - wa0);

        // Reset while a write is in ISSUE.
        access("pre_rst_rd", 2, 1'b0, 'h0AA, 0, 0);
        raise(2, 1'b1, 'h0AA, 'h777);
        step();
        check("mid_state_issue", dbg_state, ST_ISSUE);
        check("mid_memWrEn", bus.memWrEn, 1);
        #2 rstN = 1'b0;
        #1;
        check("mid_rst_memWrEn", bus.memWrEn, 0);
        check("mid_rst_ack",     bus.ack, 0);
        check("mid_rst_state",   dbg_state, ST_IDLE);
        check("mid_rst_memAddr", bus.memAddress, 0);
        check("mid_rst_memDin",  bus.memDataIn, 0);
        check("mid_rst_rdData",  bus.rdData, 0);
        clear_model();
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_hold_ack", bus.ack, 0);
        end
        rstN = 1'b1;
        access("post_rst_rd", 1, 1'b0, 'h0AA, 0, 'h000);
        access("rewrite",     2, 1'b1, 'h0AA, 'h777, 'h000);
        access("reread",      3, 1'b0, 'h0AA, 0, 'h777);
        check("final_exp_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
